// File: rtl/seg_pkg.sv
// Shared page encodings, segment constants and the hex-to-segment decoder
// for the front-panel display scheduler.
package seg_pkg;

  localparam logic [1:0] PG_RAW    = 2'd0;
  localparam logic [1:0] PG_ESENSE = 2'd1;
  localparam logic [1:0] PG_BLINK  = 2'd2;

  // State encodings equal the page encodings, so the state register drives the page pins directly.
  typedef enum logic [1:0] {
    S_RAW    = 2'd0,
    S_ESENSE = 2'd1,
    S_BLINK  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Common-anode, active-low segments; bit7 (dp) stays off.
  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 8'hC0;
      4'h1: hex2seg = 8'hF9;
      4'h2: hex2seg = 8'hA4;
      4'h3: hex2seg = 8'hB0;
      4'h4: hex2seg = 8'h99;
      4'h5: hex2seg = 8'h92;
      4'h6: hex2seg = 8'h82;
      4'h7: hex2seg = 8'hF8;
      4'h8: hex2seg = 8'h80;
      4'h9: hex2seg = 8'h90;
      4'hA: hex2seg = 8'h88;
      4'hB: hex2seg = 8'h83;
      4'hC: hex2seg = 8'hC6;
      4'hD: hex2seg = 8'hA1;
      4'hE: hex2seg = 8'h86;
      default: hex2seg = 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/seg_page_scheduler_if.sv
// Bundle of the scheduler's data inputs and display pins.
interface seg_page_scheduler_if;
  // Sources use valid-only strobes with no ready: data is captured on any cycle its valid is 1.
  logic [15:0] raw_data;
  logic        raw_valid;
  logic [23:0] esense_data;
  logic        esense_valid;
  logic        blink;
  logic [7:0]  sm_seg;
  logic [7:0]  sm_bit;
  logic [1:0]  page;

  modport master (
    output raw_data, raw_valid, esense_data, esense_valid, blink,
    input  sm_seg, sm_bit, page
  );

  modport slave (
    input  raw_data, raw_valid, esense_data, esense_valid, blink,
    output sm_seg, sm_bit, page
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Digit-scan prescaler and digit counter; tick marks the last cycle of a digit dwell.
module seg_scan_timer #(
  parameter int SCAN_DIV = 26250
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [2:0] digit,
  output logic       frame_end
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    digit_d = tick ? digit_q + 3'd1 : digit_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign frame_end = tick && (digit_q == 3'd7);
endmodule

// File: rtl/seg_page_scheduler.sv
// 8-digit display scheduler: rotates RAW/ESENSE pages per frame count, blink pre-empts for a hold.
// Optional build macro SEG_STALE_BLANK_EN shows dashes for sources that stopped updating.
module seg_page_scheduler
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 26250,
  parameter int PAGE_FRAMES  = 400,
  parameter int BLINK_HOLD   = 200,
  parameter int STALE_FRAMES = 800
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_page_scheduler_if.slave  bus
);
  localparam int RW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam int HW = (BLINK_HOLD > 1) ? $clog2(BLINK_HOLD) : 1;

  logic          tick, frame_end;
  logic [2:0]    digit, next_digit;
  logic [15:0]   raw_cap_q, raw_cap_d, raw_sh_q, raw_sh_d;
  logic [23:0]   es_cap_q, es_cap_d, es_sh_q, es_sh_d;
  logic [15:0]   bcnt_q, bcnt_d, bcnt_sh_q, bcnt_sh_d;
  state_e        state_q, state_d, ret_q, ret_d;
  logic [RW-1:0] rot_q, rot_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    sm_seg_q, sm_seg_d, sm_bit_q, sm_bit_d, seg_n;
  logic [31:0]   es_ext;
  logic          raw_stale, es_stale;

  seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .digit     (digit),
    .frame_end (frame_end)
  );

  // The *_sh_d values are what the frame starting at this tick will show, keeping digit 0 tear-free.
  always_comb begin
    raw_cap_d = bus.raw_valid ? bus.raw_data : raw_cap_q;
    es_cap_d  = bus.esense_valid ? bus.esense_data : es_cap_q;
    bcnt_d    = bus.blink ? bcnt_q + 16'd1 : bcnt_q;
    raw_sh_d  = frame_end ? raw_cap_q : raw_sh_q;
    es_sh_d   = frame_end ? es_cap_q : es_sh_q;
    bcnt_sh_d = frame_end ? bcnt_q : bcnt_sh_q;
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rot_d   = rot_q;
    hold_d  = hold_q;
    case (state_q)
      S_RAW, S_ESENSE: begin
        if (bus.blink) begin
          ret_d   = state_q;
          state_d = S_BLINK;
          hold_d  = HW'(BLINK_HOLD - 1);
        end else if (frame_end) begin
          if (rot_q == RW'(PAGE_FRAMES - 1)) begin
            rot_d   = '0;
            state_d = (state_q == S_RAW) ? S_ESENSE : S_RAW;
          end else begin
            rot_d = rot_q + RW'(1);
          end
        end
      end
      S_BLINK: begin
        if (bus.blink) begin
          hold_d = HW'(BLINK_HOLD - 1);
        end else if (frame_end) begin
          if (hold_q == '0) begin
            state_d = ret_q;
            rot_d   = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
      default: state_d = S_RAW;
    endcase
  end

`ifdef SEG_STALE_BLANK_EN
  localparam int AW = $clog2(STALE_FRAMES + 1);

  logic [AW-1:0] raw_age_q, raw_age_d, es_age_q, es_age_d;

  always_comb begin
    raw_age_d = raw_age_q;
    es_age_d  = es_age_q;
    if (bus.raw_valid)
      raw_age_d = '0;
    else if (frame_end && raw_age_q != AW'(STALE_FRAMES))
      raw_age_d = raw_age_q + AW'(1);
    if (bus.esense_valid)
      es_age_d = '0;
    else if (frame_end && es_age_q != AW'(STALE_FRAMES))
      es_age_d = es_age_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_age_q <= '0;
      es_age_q  <= '0;
    end else begin
      raw_age_q <= raw_age_d;
      es_age_q  <= es_age_d;
    end
  end

  assign raw_stale = (raw_age_d == AW'(STALE_FRAMES));
  assign es_stale  = (es_age_d == AW'(STALE_FRAMES));
`else
  logic unused_stale_cfg;
  assign unused_stale_cfg = ^STALE_FRAMES;
  assign raw_stale        = 1'b0;
  assign es_stale         = 1'b0;
`endif

  // Segment pattern for the digit that becomes active at the coming tick.
  always_comb begin
    next_digit = digit + 3'd1;
    es_ext     = {8'h00, es_sh_d};
    seg_n      = SEG_BLANK;
    case (state_d)
      S_RAW:
        if (!next_digit[2])
          seg_n = raw_stale ? SEG_DASH : hex2seg(raw_sh_d[{next_digit[1:0], 2'b00} +: 4]);
      S_ESENSE:
        if (next_digit < 3'd6)
          seg_n = es_stale ? SEG_DASH : hex2seg(es_ext[{next_digit, 2'b00} +: 4]);
      S_BLINK:
        if (!next_digit[2])
          seg_n = hex2seg(bcnt_sh_d[{next_digit[1:0], 2'b00} +: 4]);
      default: seg_n = SEG_BLANK;
    endcase
    sm_bit_d = tick ? ~(8'd1 << next_digit) : sm_bit_q;
    sm_seg_d = tick ? seg_n : sm_seg_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_cap_q <= '0;
      es_cap_q  <= '0;
      bcnt_q    <= '0;
      raw_sh_q  <= '0;
      es_sh_q   <= '0;
      bcnt_sh_q <= '0;
      state_q   <= S_RAW;
      ret_q     <= S_RAW;
      rot_q     <= '0;
      hold_q    <= '0;
      sm_seg_q  <= SEG_BLANK;
      sm_bit_q  <= 8'hFE;
    end else begin
      raw_cap_q <= raw_cap_d;
      es_cap_q  <= es_cap_d;
      bcnt_q    <= bcnt_d;
      raw_sh_q  <= raw_sh_d;
      es_sh_q   <= es_sh_d;
      bcnt_sh_q <= bcnt_sh_d;
      state_q   <= state_d;
      ret_q     <= ret_d;
      rot_q     <= rot_d;
      hold_q    <= hold_d;
      sm_seg_q  <= sm_seg_d;
      sm_bit_q  <= sm_bit_d;
    end
  end

  assign bus.sm_seg = sm_seg_q;
  assign bus.sm_bit = sm_bit_q;
  assign bus.page   = state_q;
endmodule

// File: tb/tb_seg_page_scheduler.sv
// Directed bench for seg_page_scheduler with SCAN_DIV=4 (one frame = 32 clk), PAGE_FRAMES=2,
// BLINK_HOLD=3, STALE_FRAMES=4. cyc counts rising edges since the last reset release.
module tb_seg_page_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  seg_page_scheduler_if bus();

  seg_page_scheduler #(
    .SCAN_DIV     (4),
    .PAGE_FRAMES  (2),
    .BLINK_HOLD   (3),
    .STALE_FRAMES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Advance to the falling edge that follows rising edge number c.
  task automatic goto(input int c);
    if (cyc > c) begin
      $display("FAIL timeline cyc=%0d already past required=%0d", cyc, c);
      $fatal(1, "bench timeline broken");
    end
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_raw(input logic [15:0] d);
    bus.raw_data  = d;
    bus.raw_valid = 1'b1;
    @(negedge clk);
    bus.raw_valid = 1'b0;
  endtask

  task automatic pulse_esense(input logic [23:0] d);
    bus.esense_data  = d;
    bus.esense_valid = 1'b1;
    @(negedge clk);
    bus.esense_valid = 1'b0;
  endtask

  task automatic pulse_blink();
    bus.blink = 1'b1;
    @(negedge clk);
    bus.blink = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.sm_bit !== 8'hFE) begin errors++; $display("FAIL reset_sm_bit got=%h required=fe", bus.sm_bit); end
    vectors++;
    if (bus.sm_seg !== 8'hFF) begin errors++; $display("FAIL reset_sm_seg got=%h required=ff", bus.sm_seg); end
    vectors++;
    if (bus.page !== 2'd0) begin errors++; $display("FAIL reset_page got=%0d required=0", bus.page); end
    rst = 1'b1;
  endtask

  task automatic test_scan();
    logic [7:0] eb;
    goto(2);
    vectors++;
    if (bus.sm_seg !== 8'hFF) begin errors++; $display("FAIL scan_seg_first got=%h required=ff", bus.sm_seg); end
    for (int n = 0; n < 10; n++) begin
      goto(4 * n + 2);
      eb = ~(8'd1 << (n % 8));
      vectors++;
      if (bus.sm_bit !== eb) begin errors++; $display("FAIL scan_sm_bit step%0d got=%h required=%h", n, bus.sm_bit, eb); end
    end
  endtask

  task automatic test_raw_capture();
    logic [7:0] exp_seg [8];
    exp_seg = '{8'h83, 8'hA4, 8'h88, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    goto(40);
    pulse_raw(16'h1A2B);
    goto(46);
    vectors++;
    if (bus.sm_seg !== 8'hC0) begin errors++; $display("FAIL raw_no_tear got=%h required=c0", bus.sm_seg); end
    for (int n = 0; n < 8; n++) begin
      goto(128 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== exp_seg[n]) begin errors++; $display("FAIL raw_digit%0d got=%h required=%h", n, bus.sm_seg, exp_seg[n]); end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_seg [8];
    exp_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF};
    goto(170);
    pulse_esense(24'h123456);
    goto(190);
    vectors++;
    if (bus.page !== 2'd0) begin errors++; $display("FAIL rot_page_before got=%0d required=0", bus.page); end
    goto(194);
    vectors++;
    if (bus.page !== 2'd1) begin errors++; $display("FAIL rot_page_switch got=%0d required=1", bus.page); end
    for (int n = 0; n < 8; n++) begin
      goto(192 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== exp_seg[n]) begin errors++; $display("FAIL esense_digit%0d got=%h required=%h", n, bus.sm_seg, exp_seg[n]); end
    end
    goto(258);
    vectors++;
    if (bus.page !== 2'd0) begin errors++; $display("FAIL rot_page_back got=%0d required=0", bus.page); end
    goto(322);
    vectors++;
    if (bus.page !== 2'd1) begin errors++; $display("FAIL rot_page_again got=%0d required=1", bus.page); end
  endtask

  task automatic test_blink();
    logic [7:0] exp_seg [5];
    exp_seg = '{8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hFF};
    goto(330);
    pulse_blink();
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL blink_page_next got=%0d required=2", bus.page); end
    for (int n = 0; n < 5; n++) begin
      goto(352 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== exp_seg[n]) begin errors++; $display("FAIL blink_digit%0d got=%h required=%h", n, bus.sm_seg, exp_seg[n]); end
    end
    goto(390);
    pulse_blink();
    goto(418);
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL blink_extend_page got=%0d required=2", bus.page); end
    vectors++;
    if (bus.sm_seg !== 8'hA4) begin errors++; $display("FAIL blink_count2 got=%h required=a4", bus.sm_seg); end
    goto(478);
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL blink_hold_end got=%0d required=2", bus.page); end
    goto(482);
    vectors++;
    if (bus.page !== 2'd1) begin errors++; $display("FAIL blink_return got=%0d required=1", bus.page); end
  endtask

  task automatic test_coincident();
    goto(543);
    pulse_blink();
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL coin_page got=%0d required=2", bus.page); end
    goto(578);
    vectors++;
    if (bus.sm_seg !== 8'hB0) begin errors++; $display("FAIL coin_count3 got=%h required=b0", bus.sm_seg); end
    goto(638);
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL coin_hold got=%0d required=2", bus.page); end
    goto(642);
    vectors++;
    if (bus.page !== 2'd1) begin errors++; $display("FAIL coin_no_rotation got=%0d required=1", bus.page); end
  endtask

  task automatic test_wrap();
    goto(650);
    bus.blink = 1'b1;
    repeat (65532) @(negedge clk);
    bus.blink = 1'b0;
    for (int n = 0; n < 4; n++) begin
      goto(66208 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== 8'h8E) begin errors++; $display("FAIL wrap_ffff_digit%0d got=%h required=8e", n, bus.sm_seg); end
    end
    goto(66226);
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL wrap_page got=%0d required=2", bus.page); end
    goto(66230);
    pulse_blink();
    for (int n = 0; n < 4; n++) begin
      goto(66240 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== 8'hC0) begin errors++; $display("FAIL wrap_0000_digit%0d got=%h required=c0", n, bus.sm_seg); end
    end
  endtask

  task automatic test_stale();
    logic [7:0] exp_old [4];
    logic [7:0] exp_new [4];
    exp_new = '{8'h90, 8'hB0, 8'h8E, 8'hC0};
`ifdef SEG_STALE_BLANK_EN
    exp_old = '{8'hBF, 8'hBF, 8'hBF, 8'hBF};
`else
    exp_old = '{8'hF8, 8'hC0, 8'hC6, 8'h92};
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    goto(2);
    pulse_raw(16'h5C07);
    goto(34);
    vectors++;
    if (bus.sm_seg !== 8'hF8) begin errors++; $display("FAIL stale_fresh_digit0 got=%h required=f8", bus.sm_seg); end
    goto(46);
    vectors++;
    if (bus.sm_seg !== 8'h92) begin errors++; $display("FAIL stale_fresh_digit3 got=%h required=92", bus.sm_seg); end
    for (int n = 0; n < 3; n++) begin
      goto(128 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== exp_old[n]) begin errors++; $display("FAIL stale_digit%0d got=%h required=%h", n, bus.sm_seg, exp_old[n]); end
    end
    goto(140);
    pulse_raw(16'h0F39);
    goto(142);
    vectors++;
    if (bus.sm_seg !== exp_old[3]) begin errors++; $display("FAIL stale_digit3 got=%h required=%h", bus.sm_seg, exp_old[3]); end
    for (int n = 0; n < 4; n++) begin
      goto(160 + 4 * n + 2);
      vectors++;
      if (bus.sm_seg !== exp_new[n]) begin errors++; $display("FAIL stale_recover_digit%0d got=%h required=%h", n, bus.sm_seg, exp_new[n]); end
    end
  endtask

  task automatic test_reset_mid_blink();
    goto(180);
    pulse_blink();
    vectors++;
    if (bus.page !== 2'd2) begin errors++; $display("FAIL midrst_pre_page got=%0d required=2", bus.page); end
    vectors++;
    if (bus.sm_bit !== 8'hDF) begin errors++; $display("FAIL midrst_pre_sm_bit got=%h required=df", bus.sm_bit); end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.page !== 2'd0) begin errors++; $display("FAIL midrst_page got=%0d required=0", bus.page); end
    vectors++;
    if (bus.sm_bit !== 8'hFE) begin errors++; $display("FAIL midrst_sm_bit got=%h required=fe", bus.sm_bit); end
    vectors++;
    if (bus.sm_seg !== 8'hFF) begin errors++; $display("FAIL midrst_sm_seg got=%h required=ff", bus.sm_seg); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.raw_data     = '0;
    bus.raw_valid    = 1'b0;
    bus.esense_data  = '0;
    bus.esense_valid = 1'b0;
    bus.blink        = 1'b0;
    test_reset();
    test_scan();
    test_raw_capture();
    test_rotation();
    test_blink();
    test_coincident();
    test_wrap();
    test_stale();
    test_reset_mid_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
